// File: rtl/seg7_frame_decoder_pkg.sv
// Shared seven-segment constants: active-low segment patterns (seg6..seg0) and frame geometry.
// Also used by the display encoder.
package seg7_frame_decoder_pkg;

   localparam int unsigned FRAME_BITS = 14;
   localparam int unsigned SEG_W      = 7;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned ERR_W      = 4;
   localparam int unsigned SEG_COUNT  = 16;

   localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
   localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
   localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
   localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
   localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

   // Index n holds the pattern for hex digit n.
   localparam logic [SEG_COUNT-1:0][SEG_W-1:0] SEG_TABLE = {
      SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
      SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
   };

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   typedef struct packed {
      logic [NIB_W-1:0] hi;
      logic [NIB_W-1:0] lo;
   } hex_byte_t;

endpackage

// File: rtl/seg7_frame_decoder_if.sv
// Serial frame input and decoded-byte output bundle of the seven-segment frame decoder.
interface seg7_frame_decoder_if;
   import seg7_frame_decoder_pkg::*;

   logic              enable;
   logic              ser_in;
   logic              frame_start;
   logic [BYTE_W-1:0] byte_out;
   logic              byte_valid;
   logic              frame_err;
   logic [ERR_W-1:0]  err_count;

   modport master (
      output enable, ser_in, frame_start,
      input  byte_out, byte_valid, frame_err, err_count
   );

   modport slave (
      input  enable, ser_in, frame_start,
      output byte_out, byte_valid, frame_err, err_count
   );

endinterface

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup of an active-low segment pattern to its hex nibble.
module seg7_to_hex
   import seg7_frame_decoder_pkg::*;
(
   input  logic [SEG_W-1:0] pattern,
   output logic [NIB_W-1:0] nibble,
   output logic             pattern_ok
);

   always_comb begin
      nibble     = '0;
      pattern_ok = 1'b0;
      for (int i = 0; i < SEG_COUNT; i++) begin
         if (pattern == SEG_TABLE[i]) begin
            nibble     = NIB_W'(i);
            pattern_ok = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Shifts in 14-bit serial frames of two seven-segment patterns and decodes them to one byte;
// unknown patterns and frames restarted mid-way raise a one-cycle error pulse.
module seg7_frame_decoder
   import seg7_frame_decoder_pkg::*;
(
   input logic                 clk,
   input logic                 clear_b,
   seg7_frame_decoder_if.slave bus
);

   state_t                  state;
   logic [CNT_W-1:0]        bit_cnt;
   logic [FRAME_BITS-2:0]   shreg;
   hex_byte_t               byte_q;
   logic                    valid_q;
   logic                    err_q;
   logic [ERR_W-1:0]        err_cnt_q;

   logic [FRAME_BITS-1:0]   frame_c;
   logic [NIB_W-1:0]        hi_nib_c;
   logic [NIB_W-1:0]        lo_nib_c;
   logic                    hi_ok_c;
   logic                    lo_ok_c;
   logic                    last_bit_c;

   // Decode the frame as it would look with the current bit appended.
   assign frame_c    = {shreg, bus.ser_in};
   assign last_bit_c = (bit_cnt == CNT_W'(FRAME_BITS - 1));

   seg7_to_hex u_hi (
      .pattern    (frame_c[FRAME_BITS-1:SEG_W]),
      .nibble     (hi_nib_c),
      .pattern_ok (hi_ok_c)
   );

   seg7_to_hex u_lo (
      .pattern    (frame_c[SEG_W-1:0]),
      .nibble     (lo_nib_c),
      .pattern_ok (lo_ok_c)
   );

   always_ff @(posedge clk or negedge clear_b) begin
      if (!clear_b) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         byte_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         if (bus.enable) begin
            case (state)
               ST_IDLE: begin
                  if (bus.frame_start) begin
                     shreg   <= (FRAME_BITS-1)'(bus.ser_in);
                     bit_cnt <= CNT_W'(1);
                     state   <= ST_SHIFT;
                  end
               end
               ST_SHIFT: begin
                  if (bus.frame_start) begin
                     // Restart: drop the partial frame, this bit opens the new one.
                     err_q   <= 1'b1;
                     if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_W'(1);
                     shreg   <= (FRAME_BITS-1)'(bus.ser_in);
                     bit_cnt <= CNT_W'(1);
                  end else if (last_bit_c) begin
                     if (hi_ok_c && lo_ok_c) begin
                        byte_q  <= '{hi: hi_nib_c, lo: lo_nib_c};
                        valid_q <= 1'b1;
                     end else begin
                        err_q <= 1'b1;
                        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_W'(1);
                     end
                     shreg   <= '0;
                     bit_cnt <= '0;
                     state   <= ST_IDLE;
                  end else begin
                     shreg   <= frame_c[FRAME_BITS-2:0];
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.byte_out   = byte_q;
   assign bus.byte_valid = valid_q;
   assign bus.frame_err  = err_q;
   assign bus.err_count  = err_cnt_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Scoreboard bench for seg7_frame_decoder: a bit-queue reference model predicts every output
// pulse; a negedge monitor pops and compares whenever byte_valid or frame_err is seen.
module tb_seg7_frame_decoder;

   logic clk = 1'b0;
   logic clear_b;
   always #5 clk = ~clk;

   seg7_frame_decoder_if bus ();

   seg7_frame_decoder dut (
      .clk     (clk),
      .clear_b (clear_b),
      .bus     (bus)
   );

   typedef struct {
      int kind;      // 1 = byte_valid, 2 = frame_err
      int byte_val;
      int err;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   int ref_seg[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   bit ref_active = 1'b0;
   bit ref_bits[$];
   int ref_byte = 0;
   int ref_err  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int seg_value(input int pat);
      for (int k = 0; k < 16; k++) if (ref_seg[k] == pat) return k;
      return -1;
   endfunction

   function automatic void ref_error();
      ref_err = (ref_err < 15) ? ref_err + 1 : 15;
      exp_q.push_back('{2, ref_byte, ref_err});
   endfunction

   // One clock of stimulus; the model reacts to the bit accepted on this edge.
   task automatic drive(input bit en, input bit fs, input bit b);
      @(negedge clk);
      bus.enable      = en;
      bus.frame_start = fs;
      bus.ser_in      = b;
      @(posedge clk);
      if (en) begin
         if (fs) begin
            if (ref_active) ref_error();
            ref_bits.delete();
            ref_bits.push_back(b);
            ref_active = 1'b1;
         end else if (ref_active) begin
            ref_bits.push_back(b);
            if (ref_bits.size() == 14) begin
               int hv = 0;
               int lv = 0;
               int hd, ld;
               for (int i = 0; i < 7; i++)  hv = hv * 2 + int'(ref_bits[i]);
               for (int i = 7; i < 14; i++) lv = lv * 2 + int'(ref_bits[i]);
               hd = seg_value(hv);
               ld = seg_value(lv);
               if (hd >= 0 && ld >= 0) begin
                  ref_byte = hd * 16 + ld;
                  exp_q.push_back('{1, ref_byte, ref_err});
               end else begin
                  ref_error();
               end
               ref_active = 1'b0;
               ref_bits.delete();
            end
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0);
   endtask

   // Sends the first n_bits of frame {hi,lo}; optionally stalls enable after bit stall_at.
   task automatic send_frame(input int hi, input int lo, input int stall_at,
                             input int stall_len, input int n_bits);
      for (int i = 0; i < n_bits; i++) begin
         bit b;
         b = (i < 7) ? 1'((hi >> (6 - i)) & 1) : 1'((lo >> (13 - i)) & 1);
         drive(1'b1, i == 0, b);
         if (i + 1 == stall_at)
            repeat (stall_len) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (clear_b === 1'b1) begin
         if (bus.byte_valid && bus.frame_err) begin
            n_cmp++;
            n_bad++;
            $display("FAIL both_pulses: byte_valid and frame_err high together (t=%0t)", $time);
         end else if (bus.byte_valid || bus.frame_err) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_pulse: valid=%0b err=%0b, expected none (t=%0t)",
                        bus.byte_valid, bus.frame_err, $time);
            end else begin
               e = exp_q.pop_front();
               check("pulse_kind", bus.byte_valid ? 1 : 2, e.kind);
               check("byte_out",   int'(bus.byte_out), e.byte_val);
               check("err_count",  int'(bus.err_count), e.err);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      clear_b         = 1'b0;
      bus.enable      = 1'b0;
      bus.frame_start = 1'b0;
      bus.ser_in      = 1'b0;
      #1;
      check("rst_byte_out",   int'(bus.byte_out), 0);
      check("rst_byte_valid", int'(bus.byte_valid), 0);
      check("rst_frame_err",  int'(bus.frame_err), 0);
      check("rst_err_count",  int'(bus.err_count), 0);
      repeat (2) @(negedge clk);
      clear_b = 1'b1;
      idle(2);

      // 0x3A straight, then with a 5-cycle enable stall after bit 6
      send_frame(7'h30, 7'h08, 0, 0, 14);
      idle(2);
      send_frame(7'h30, 7'h08, 6, 5, 14);
      idle(2);

      // Blank high digit: error, byte_out stays 0x3A, err_count 1
      send_frame(7'h7F, 7'h40, 0, 0, 14);
      idle(2);

      // Restart at bit 9, then a full 0xF0 frame
      send_frame(7'h12, 7'h79, 0, 0, 8);
      send_frame(7'h0E, 7'h40, 0, 0, 14);
      idle(2);

      // 17 invalid frames back-to-back: err_count saturates
      for (int k = 0; k < 17; k++) send_frame(7'h7F, 7'h7F, 0, 0, 14);
      idle(2);
      check("err_saturated", int'(bus.err_count), 15);
      check("byte_kept_f0",  int'(bus.byte_out), 8'hF0);

      // Reset at bit 10 of a frame, then 0x55
      send_frame(7'h24, 7'h19, 0, 0, 9);
      @(negedge clk);
      clear_b = 1'b0;
      #1;
      check("midrst_byte_out",   int'(bus.byte_out), 0);
      check("midrst_byte_valid", int'(bus.byte_valid), 0);
      check("midrst_frame_err",  int'(bus.frame_err), 0);
      check("midrst_err_count",  int'(bus.err_count), 0);
      ref_active = 1'b0;
      ref_bits.delete();
      ref_byte = 0;
      ref_err  = 0;
      @(negedge clk);
      clear_b = 1'b1;
      send_frame(7'h12, 7'h12, 0, 0, 14);
      idle(2);
      check("after_rst_byte", int'(bus.byte_out), 8'h55);

      // Randomized traffic: valid/invalid frames, aborts, stalls, noise, back-to-back
      for (int k = 0; k < 250; k++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 5)
            send_frame(ref_seg[$urandom_range(0, 15)], ref_seg[$urandom_range(0, 15)],
                       $urandom_range(0, 13), $urandom_range(0, 3), 14);
         else if (r < 7)
            send_frame($urandom_range(0, 127), $urandom_range(0, 127), 0, 0, 14);
         else if (r < 8)
            send_frame(ref_seg[$urandom_range(0, 15)], ref_seg[$urandom_range(0, 15)], 0, 0,
                       $urandom_range(1, 13));
         else
            repeat ($urandom_range(1, 4))
               drive(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
      end

      idle(4);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
